hpdl1414_bus_responder: RTL and testbench

- Display-side counterpart of the HPDL-1414 parallel write bus driven by the display controller.
- Snoops the D[6:0], A[1:0] and WR1..WR4 bus exactly as four HPDL-1414 devices would, and latches each written character into a 16-entry shadow buffer.
- On request, transmits the buffer contents back over UART (8N1).
- Used for in-system readback and as a bench/board monitor for the display controller.

---
 rtl/hpdl1414_bus_responder.sv | 111 +++++++++++
 tb/tb_hpdl1414_bus_responder.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/hpdl1414_bus_responder.sv
// hpdl1414_bus_responder: snoops an HPDL-1414 write bus into a 16-char shadow buffer and dumps it over UART 8N1.
module hpdl1414_bus_responder #(
  parameter int CLK_HZ = 12000000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] hpdl_d,
  input  logic [1:0] hpdl_a,
  input  logic [3:0] hpdl_wr_n,
  input  logic       dump_i,
  output logic       uart_tx,
  output logic       busy,
  output logic       collision,
  output logic [7:0] write_count
);
  localparam int CPB = CLK_HZ / BAUD;
  localparam int CW  = $clog2(CPB);

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

  logic [6:0] d_s1, d_s2, d_p;
  logic [1:0] a_s1, a_s2, a_p;
  logic [3:0] wr_s1, wr_s2, wr_p;
  logic       dump_s1, dump_s2, dump_p;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      d_s1 <= '0; d_s2 <= '0; d_p <= '0;
      a_s1 <= '0; a_s2 <= '0; a_p <= '0;
      wr_s1 <= '1; wr_s2 <= '1; wr_p <= '1;
      dump_s1 <= 1'b0; dump_s2 <= 1'b0; dump_p <= 1'b0;
    end else begin
      d_s1 <= hpdl_d; d_s2 <= d_s1; d_p <= d_s2;
      a_s1 <= hpdl_a; a_s2 <= a_s1; a_p <= a_s2;
      wr_s1 <= hpdl_wr_n; wr_s2 <= wr_s1; wr_p <= wr_s2;
      dump_s1 <= dump_i; dump_s2 <= dump_s1; dump_p <= dump_s2;
    end

  logic [3:0] rise;
  logic [1:0] k;
  logic       collide, dump_rise;

  // The prev stage still holds the data seen while WR was low, like the device latch.
  always_comb begin
    rise      = ~wr_p & wr_s2;
    k         = rise[0] ? 2'd0 : rise[1] ? 2'd1 : rise[2] ? 2'd2 : 2'd3;
    collide   = |(rise & (rise - 4'd1));
    dump_rise = dump_s2 & ~dump_p;
  end

  logic [6:0] shadow [16];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) shadow[i] <= 7'h20;
      write_count <= '0;
      collision   <= 1'b0;
    end else begin
      if (|rise) begin
        shadow[{k, a_p}] <= d_p;
        write_count      <= write_count + 8'd1;
      end
      collision <= collision | collide;
    end

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [4:0]    n;
  logic [7:0]    shifter, byte_sel;
  logic          bit_end;

  always_comb begin
    bit_end  = cnt == CW'(CPB - 1);
    byte_sel = n < 5'd16 ? {1'b0, shadow[n[3:0]]} : n == 5'd16 ? 8'h0D : 8'h0A;
    state_n  = state;
    case (state)
      IDLE:    if (dump_rise) state_n = LOAD;
      LOAD:    state_n = START;
      START:   if (bit_end) state_n = DATA;
      DATA:    if (bit_end && bit_idx == 3'd7) state_n = STOP;
      STOP:    if (bit_end) state_n = n == 5'd17 ? IDLE : LOAD;
      default: state_n = IDLE;
    endcase
    uart_tx = state == START ? 1'b0 : state == DATA ? shifter[0] : 1'b1;
    busy    = state != IDLE;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      n       <= '0;
      shifter <= '1;
    end else begin
      state <= state_n;
      cnt   <= (state == LOAD || bit_end) ? '0 : cnt + 1'b1;
      if (state == IDLE && dump_rise) n <= '0;
      if (state == LOAD) begin
        shifter <= byte_sel;
        bit_idx <= '0;
      end
      if (state == DATA && bit_end) begin
        shifter <= shifter >> 1;
        bit_idx <= bit_idx + 3'd1;
      end
      if (state == STOP && bit_end) n <= n + 5'd1;
    end
endmodule

// File: tb/tb_hpdl1414_bus_responder.sv
// tb_hpdl1414_bus_responder: random bus writes and dumps checked against a character-buffer model and a UART decoder.
module tb_hpdl1414_bus_responder;
  logic       clk = 0, rst_n = 0, dump_i = 0;
  logic [6:0] hpdl_d = '0;
  logic [1:0] hpdl_a = '0;
  logic [3:0] hpdl_wr_n = 4'hF;
  logic       uart_tx, busy, collision;
  logic [7:0] write_count;

  hpdl1414_bus_responder #(.CLK_HZ(1000000), .BAUD(100000)) dut (
    .clk(clk), .rst_n(rst_n), .hpdl_d(hpdl_d), .hpdl_a(hpdl_a), .hpdl_wr_n(hpdl_wr_n),
    .dump_i(dump_i), .uart_tx(uart_tx), .busy(busy), .collision(collision), .write_count(write_count)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, busy_cycles = 0;
  logic [7:0] mdl [16];
  int m_count;
  bit m_coll;

  always @(posedge clk) if (busy) busy_cycles <= busy_cycles + 1;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(int c);
    repeat (c) begin @(posedge clk); #1; end
  endtask

  task automatic model_reset;
    for (int i = 0; i < 16; i++) mdl[i] = 8'h20;
    m_count = 0;
    m_coll = 0;
  endtask

  task automatic wr(logic [3:0] mask, logic [6:0] d, logic [1:0] a);
    int kk = 0;
    hpdl_d = d; hpdl_a = a;
    tick(1);
    hpdl_wr_n = ~mask;
    tick(5);
    hpdl_wr_n = 4'hF;
    for (int i = 3; i >= 0; i--) if (mask[i]) kk = i;
    mdl[kk * 4 + int'(a)] = {1'b0, d};
    m_count = (m_count + 1) % 256;
    if ($countones(mask) > 1) m_coll = 1;
    tick(4);
  endtask

  task automatic pulse_dump;
    dump_i = 1; tick(2); dump_i = 0;
  endtask

  task automatic rx_byte(output logic [7:0] b, output bit ok);
    int t = 0;
    ok = 0; b = '0;
    while (uart_tx !== 1'b0 && t < 400) begin tick(1); t++; end
    if (uart_tx !== 1'b0) return;
    tick(5);
    for (int i = 0; i < 8; i++) begin tick(10); b[i] = uart_tx; end
    tick(10);
    ok = uart_tx === 1'b1;
  endtask

  task automatic rx_dump(string tag);
    logic [7:0] b, exp;
    bit ok;
    for (int i = 0; i < 18; i++) begin
      rx_byte(b, ok);
      check($sformatf("%s_frame%0d", tag, i), ok, 1);
      if (!ok) return;
      exp = i < 16 ? mdl[i] : i == 16 ? 8'h0D : 8'h0A;
      check($sformatf("%s_byte%0d", tag, i), b, exp);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b0;
    model_reset;
    tick(3);
    check("rst_tx", uart_tx, 1);
    check("rst_busy", busy, 0);
    check("rst_coll", collision, 0);
    check("rst_count", write_count, 0);
    rst_n = 1;
    tick(2);
    b0 = busy_cycles;
    pulse_dump;
    rx_dump("s1");
    tick(10);
    check("s1_busy_len", busy_cycles - b0, 1818);
    check("s1_count", write_count, 0);
    hpdl_d = 7'h41; hpdl_a = 2'd2;
    tick(1);
    hpdl_wr_n = 4'b1101;
    tick(5);
    hpdl_wr_n = 4'hF;
    tick(2);
    check("s2_lat_early", write_count, 0);
    tick(1);
    check("s2_lat", write_count, 1);
    mdl[6] = 8'h41; m_count = 1;
    tick(2);
    pulse_dump;
    rx_dump("s2");
    tick(10);
    wr(4'b1001, 7'h5A, 2'd0);
    check("s3_coll", collision, 32'(m_coll));
    tick(100);
    check("s3_coll_sticky", collision, 1);
    check("s3_count", write_count, m_count);
    pulse_dump;
    rx_dump("s3");
    tick(10);
    repeat (20) wr(4'b0001 << $urandom_range(3), 7'($urandom), 2'($urandom));
    check("rnd_count", write_count, m_count);
    fork
      begin pulse_dump; rx_dump("s4"); end
      begin tick(230); wr(4'b1000, 7'h33, 2'd3); pulse_dump; end
    join
    tick(10);
    b0 = busy_cycles;
    tick(300);
    check("s4_no_requeue", busy_cycles - b0, 0);
    pulse_dump;
    tick(430);
    rst_n = 0;
    #1;
    check("s5_tx", uart_tx, 1);
    check("s5_busy", busy, 0);
    model_reset;
    check("s5_count", write_count, 0);
    check("s5_coll", collision, 0);
    tick(2);
    rst_n = 1;
    tick(2);
    pulse_dump;
    rx_dump("s5");
    tick(10);
    repeat (255) wr(4'b0001 << $urandom_range(3), 7'($urandom), 2'($urandom));
    check("s6_255", write_count, m_count);
    wr(4'b0001 << $urandom_range(3), 7'($urandom), 2'($urandom));
    check("s6_wrap", write_count, 0);
    wr(4'b0001 << $urandom_range(3), 7'($urandom), 2'($urandom));
    check("s6_after", write_count, 1);
    pulse_dump;
    rx_dump("s6");
    tick(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
